boot_stream_ctrl: RTL and testbench

- Upstream feeder for pcw_core's download port (dn_go/dn_wr/dn_addr/dn_data, execute_addr/execute_enable).
- On a boot trigger (end of system reset), it copies the boot ROM image from a synchronous ROM into core RAM starting at DN_BASE, one byte at a time.
- After the last byte it pulses execute_enable so the core starts executing at EXEC_ADDR.
- It replaces the ad-hoc loader sequencing in the top level and adds a wait handshake and abort/restart handling.

---
 rtl/boot_stream_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_boot_stream_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_stream_ctrl.sv
// -----------------------------------------------------------------------------
// boot_stream_ctrl
//   Feeds the boot ROM image into pcw_core's download port. A rising edge on
//   start (registered) copies ROM_LEN bytes from a synchronous ROM into core
//   RAM starting at DN_BASE, one byte per FETCH/LOAD/STROBE sequence. After
//   the last byte, execute_enable pulses for one clock and done is raised.
//   A start edge during a load aborts it and restarts from byte 0.
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   Accumulates an 8-bit modulo sum of the written bytes. On a mismatch with
//   CHECKSUM the load finishes with boot_err = 1 and no execute_enable.
//
// Ports:
//   clk_sys        in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   boot request, rising edge starts/restarts a load
//   model          in   ROM image select, sampled on the start edge
//   rom_model      out  latched image select for the ROM
//   rom_addr       out  ROM byte index
//   rom_data       in   ROM data, valid one clock after rom_addr changes
//   dn_go          out  high for the whole load
//   dn_wr          out  core write strobe
//   dn_addr        out  core write address
//   dn_data        out  core write data
//   dn_wait        in   core stall, stretches dn_wr while high
//   execute_addr   out  constant EXEC_ADDR
//   execute_enable out  one-clock pulse after a completed load
//   done           out  high after a completed load until the next start edge
//   boot_err       out  checksum mismatch (BOOT_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module boot_stream_ctrl #(
   parameter int unsigned       ROM_LEN   = 276,
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] DN_BASE   = '0,
   parameter logic [15:0]       EXEC_ADDR = 16'h0000
`ifdef BOOT_CHECKSUM_EN
   ,parameter logic [7:0]       CHECKSUM  = 8'h00
`endif
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              start,
   input  logic              model,
   output logic              rom_model,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              dn_go,
   output logic              dn_wr,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   input  logic              dn_wait,
   output logic [15:0]       execute_addr,
   output logic              execute_enable,
   output logic              done
`ifdef BOOT_CHECKSUM_EN
   ,output logic             boot_err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_STROBE,
      S_FINISH
   } state_t;

   // Index of the final byte; ROM_LEN may be 2^ADDR_W so the cast is exact.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_LEN - 1);

   state_t              state_q, state_d;
   logic                start_q;
   logic                start_edge;
   logic                rom_model_q, rom_model_d;
   // The byte index and the ROM address always move together, so one
   // register serves as both.
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                dn_go_q, dn_go_d;
   logic                dn_wr_q, dn_wr_d;
   logic [ADDR_W-1:0]   dn_addr_q, dn_addr_d;
   logic [7:0]          dn_data_q, dn_data_d;
   logic                exec_en_q, exec_en_d;
   logic                done_q, done_d;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]          sum_q, sum_d;
   logic                boot_err_q, boot_err_d;
`endif

   // start_q resets to 0, so start held high through reset release is seen
   // as an edge on the first clock: this is the power-on boot path.
   assign start_edge = start & ~start_q;

   always_comb begin
      // NOTE: every next-state signal gets a default before any branch so no
      // path leaves one unassigned, which would infer a latch.
      state_d     = state_q;
      rom_model_d = rom_model_q;
      idx_d       = idx_q;
      dn_go_d     = dn_go_q;
      dn_wr_d     = dn_wr_q;
      dn_addr_d   = dn_addr_q;
      dn_data_d   = dn_data_q;
      exec_en_d   = 1'b0;
      done_d      = done_q;
`ifdef BOOT_CHECKSUM_EN
      sum_d       = sum_q;
      boot_err_d  = boot_err_q;
`endif

      if (start_edge) begin
         // Start and abort/restart share one path; it also pre-empts FINISH,
         // so a restart there suppresses the execute pulse.
         idx_d       = '0;
         dn_go_d     = 1'b1;
         dn_wr_d     = 1'b0;
         done_d      = 1'b0;
         rom_model_d = model;
         state_d     = S_FETCH;
`ifdef BOOT_CHECKSUM_EN
         sum_d       = '0;
         boot_err_d  = 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: ;
            // One clock for the synchronous ROM to present rom_data.
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
               dn_data_d = rom_data;
               dn_addr_d = DN_BASE + idx_q;
               dn_wr_d   = 1'b1;
               state_d   = S_STROBE;
            end
            S_STROBE: begin
               // While dn_wait is high the strobe, address and data hold.
               if (!dn_wait) begin
                  dn_wr_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
                  sum_d   = sum_q + dn_data_q;
`endif
                  if (idx_q == LAST_IDX) begin
                     state_d = S_FINISH;
                  end else begin
                     idx_d   = idx_q + ADDR_W'(1);
                     state_d = S_FETCH;
                  end
               end
            end
            S_FINISH: begin
               dn_go_d = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
`ifdef BOOT_CHECKSUM_EN
               exec_en_d  = (sum_q == CHECKSUM);
               boot_err_d = (sum_q != CHECKSUM);
`else
               exec_en_d  = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         rom_model_q <= 1'b0;
         idx_q       <= '0;
         dn_go_q     <= 1'b0;
         dn_wr_q     <= 1'b0;
         dn_addr_q   <= '0;
         dn_data_q   <= '0;
         exec_en_q   <= 1'b0;
         done_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         sum_q       <= '0;
         boot_err_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         start_q     <= start;
         rom_model_q <= rom_model_d;
         idx_q       <= idx_d;
         dn_go_q     <= dn_go_d;
         dn_wr_q     <= dn_wr_d;
         dn_addr_q   <= dn_addr_d;
         dn_data_q   <= dn_data_d;
         exec_en_q   <= exec_en_d;
         done_q      <= done_d;
`ifdef BOOT_CHECKSUM_EN
         sum_q       <= sum_d;
         boot_err_q  <= boot_err_d;
`endif
      end
   end

   assign rom_model      = rom_model_q;
   assign rom_addr       = idx_q;
   assign dn_go          = dn_go_q;
   assign dn_wr          = dn_wr_q;
   assign dn_addr        = dn_addr_q;
   assign dn_data        = dn_data_q;
   assign execute_addr   = EXEC_ADDR;
   assign execute_enable = exec_en_q;
   assign done           = done_q;
`ifdef BOOT_CHECKSUM_EN
   assign boot_err       = boot_err_q;
`endif

endmodule

// File: tb/tb_boot_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_stream_ctrl
//   Three boot_stream_ctrl instances share start/model/dn_wait/reset_n:
//     dut0: ROM_LEN=4, DN_BASE=0000, CHECKSUM=0A (mismatch for image 0)
//     dut1: ROM_LEN=1, DN_BASE=FFFF, CHECKSUM=11 (match for image 0)
//     dut2: ROM_LEN=4, DN_BASE=FFFE, CHECKSUM=AA (match for image 0, addr wrap)
//   A progress-counter model predicts every output each cycle; directed
//   loads pin write cycles, addresses, data and execute timing with literals.
//   Build with +define+BOOT_CHECKSUM_EN to cover the checksum variant.
// -----------------------------------------------------------------------------
module tb_boot_stream_ctrl;

   localparam int NDUT = 3;
   localparam int          LEN  [NDUT] = '{4, 1, 4};
   localparam logic [15:0] BASE [NDUT] = '{16'h0000, 16'hFFFF, 16'hFFFE};
   localparam logic [15:0] EXA  [NDUT] = '{16'h1234, 16'h0000, 16'hBEEF};
   localparam logic [7:0]  CK   [NDUT] = '{8'h0A, 8'h11, 8'hAA};

   logic clk_sys = 1'b0;
   logic reset_n, start, model, dn_wait;

   logic        rom_model      [NDUT];
   logic [15:0] rom_addr       [NDUT];
   logic [7:0]  rom_data       [NDUT];
   logic        dn_go          [NDUT];
   logic        dn_wr          [NDUT];
   logic [15:0] dn_addr        [NDUT];
   logic [7:0]  dn_data        [NDUT];
   logic [15:0] execute_addr   [NDUT];
   logic        execute_enable [NDUT];
   logic        done           [NDUT];
`ifdef BOOT_CHECKSUM_EN
   logic        boot_err       [NDUT];
`endif

   always #5 clk_sys = ~clk_sys;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      boot_stream_ctrl #(
         .ROM_LEN  (LEN[g]),
         .ADDR_W   (16),
         .DN_BASE  (BASE[g]),
         .EXEC_ADDR(EXA[g])
`ifdef BOOT_CHECKSUM_EN
         ,.CHECKSUM(CK[g])
`endif
      ) u_dut (
         .clk_sys       (clk_sys),
         .reset_n       (reset_n),
         .start         (start),
         .model         (model),
         .rom_model     (rom_model[g]),
         .rom_addr      (rom_addr[g]),
         .rom_data      (rom_data[g]),
         .dn_go         (dn_go[g]),
         .dn_wr         (dn_wr[g]),
         .dn_addr       (dn_addr[g]),
         .dn_data       (dn_data[g]),
         .dn_wait       (dn_wait),
         .execute_addr  (execute_addr[g]),
         .execute_enable(execute_enable[g]),
         .done          (done[g])
`ifdef BOOT_CHECKSUM_EN
         ,.boot_err     (boot_err[g])
`endif
      );
   end

   // Two ROM images of 8 bytes; image 0 starts 11,22,33,44 (sum AA).
   logic [7:0] rom_img [2][8] = '{
      '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88},
      '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18}
   };

   // Synchronous ROM per instance, one clock latency.
   always @(posedge clk_sys)
      for (int i = 0; i < NDUT; i++)
         rom_data[i] <= rom_img[rom_model[i]][rom_addr[i][2:0]];

   // ---------------------------------------------------------------- checks
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int dut,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, dut, act, exp, $time);
      end
   endtask

   // ----------------------------------------------------------------- model
   // A load is described by its progress p (clocks of forward motion since
   // the start edge). Byte b is written while p == 3b+2; a stalled strobe
   // keeps p still. The load completes when p passes 3*LEN.
   typedef struct {
      bit          loading;
      int          p;
      bit          ee;
      bit          done;
      bit          berr;
      bit          mdl;
      logic [15:0] raddr;
      logic [15:0] addr;
      logic [7:0]  data;
   } mstate_t;

   mstate_t m [NDUT];
   bit      start_prev;

`ifdef BOOT_CHECKSUM_EN
   function automatic logic [7:0] image_sum(input bit mdl, input int len);
      logic [7:0] s = '0;
      for (int b = 0; b < len; b++) s += rom_img[mdl][b];
      return s;
   endfunction
`endif

   task automatic step(input int i, input bit e);
      int last;
      last = 3 * LEN[i];
      m[i].ee = 1'b0;
      if (e) begin
         m[i].loading = 1'b1;
         m[i].p       = 0;
         m[i].done    = 1'b0;
         m[i].berr    = 1'b0;
         m[i].mdl     = model;
      end else if (m[i].loading) begin
         if (m[i].p == last) begin
            m[i].loading = 1'b0;
            m[i].done    = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            m[i].berr    = (image_sum(m[i].mdl, LEN[i]) != CK[i]);
`endif
            m[i].ee      = !m[i].berr;
         end else if (!((m[i].p % 3 == 2) && dn_wait)) begin
            m[i].p++;
         end
      end
      if (m[i].loading) begin
         m[i].raddr = 16'((m[i].p / 3 < LEN[i]) ? m[i].p / 3 : LEN[i] - 1);
         if (m[i].p % 3 == 2) begin
            m[i].addr = 16'(BASE[i] + m[i].p / 3);
            m[i].data = rom_img[m[i].mdl][m[i].p / 3];
         end
      end
   endtask

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         start_prev = 1'b0;
         for (int i = 0; i < NDUT; i++) m[i] = '{default: 0};
      end else begin
         bit e;
         e = start && !start_prev;
         start_prev = start;
         for (int i = 0; i < NDUT; i++) step(i, e);
      end
   end

   // Per-cycle compare, away from the active edge.
   bit cmp_en = 1'b0;
   always @(negedge clk_sys) begin
      if (cmp_en) begin
         for (int i = 0; i < NDUT; i++) begin
            check("dn_go", i, dn_go[i], m[i].loading);
            check("dn_wr", i, dn_wr[i], m[i].loading && (m[i].p % 3 == 2));
            check("dn_addr", i, dn_addr[i], m[i].addr);
            check("dn_data", i, dn_data[i], m[i].data);
            check("rom_addr", i, rom_addr[i], m[i].raddr);
            check("rom_model", i, rom_model[i], m[i].mdl);
            check("execute_enable", i, execute_enable[i], m[i].ee);
            check("done", i, done[i], m[i].done);
            check("execute_addr", i, execute_addr[i], EXA[i]);
`ifdef BOOT_CHECKSUM_EN
            check("boot_err", i, boot_err[i], m[i].berr);
`endif
         end
      end
   end

   // ---------------------------------------------------- directed recording
   typedef struct { int cyc; logic [15:0] addr; logic [7:0] data; } wr_t;
   wr_t         wr_log [$];
   int          hold1, wr1_cnt, wr1_cyc;
   logic [15:0] wr1_addr;
   int          ee_cyc [NDUT];
   int          ee_cnt [NDUT];

   // One load with image 0. Cycle n is the interval after the n-th edge
   // counted from the edge that samples start. dn_wait is driven high after
   // edges ws..ws+wl-1; a restart pulse is driven after edge rs.
   task automatic run_load(input int ncyc, input int ws, input int wl, input int rs);
      wr_log.delete();
      hold1 = 0; wr1_cnt = 0; wr1_cyc = -1; wr1_addr = '0;
      for (int i = 0; i < NDUT; i++) begin ee_cyc[i] = -1; ee_cnt[i] = 0; end
      @(posedge clk_sys); #1;
      start = 1'b1; model = 1'b0; dn_wait = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk_sys); #1;
         start   = (n == rs);
         dn_wait = (n >= ws) && (n < ws + wl);
         @(negedge clk_sys);
         if (dn_wr[0]) wr_log.push_back('{n, dn_addr[0], dn_data[0]});
         if (dn_wr[0] && dn_addr[0] == 16'h0001) hold1++;
         if (dn_wr[1]) begin wr1_cnt++; wr1_cyc = n; wr1_addr = dn_addr[1]; end
         for (int i = 0; i < NDUT; i++)
            if (execute_enable[i]) begin
               ee_cnt[i]++;
               if (ee_cyc[i] < 0) ee_cyc[i] = n;
            end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- stimulus
   initial begin
      reset_n = 1'b1; start = 1'b0; model = 1'b0; dn_wait = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         check("reset dn_go", i, dn_go[i], 1'b0);
         check("reset dn_wr", i, dn_wr[i], 1'b0);
         check("reset done", i, done[i], 1'b0);
         check("reset execute_enable", i, execute_enable[i], 1'b0);
      end
      check("reset execute_addr", 0, execute_addr[0], 16'h1234);
      repeat (3) @(posedge clk_sys);
      #3 reset_n = 1'b1;
      @(negedge clk_sys);
      cmp_en = 1'b1;

      // Plain load: writes at 2,5,8,11 with data 11..44, execute at 13.
      run_load(16, -1, 0, -1);
      check("wr count", 0, wr_log.size(), 4);
      for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
         check("wr cycle", 0, wr_log[k].cyc, 2 + 3 * k);
         check("wr addr", 0, wr_log[k].addr, k);
         check("wr data", 0, wr_log[k].data, 8'h11 * (k + 1));
      end
`ifdef BOOT_CHECKSUM_EN
      check("ee count mismatch", 0, ee_cnt[0], 0);
      check("boot_err mismatch", 0, boot_err[0], 1'b1);
      check("boot_err match", 2, boot_err[2], 1'b0);
`else
      check("ee cycle", 0, ee_cyc[0], 13);
`endif
      check("ee cycle", 2, ee_cyc[2], 13);
      check("ee count", 2, ee_cnt[2], 1);
      check("done after", 0, done[0], 1'b1);
      check("dn_go after", 0, dn_go[0], 1'b0);
      check("single wr count", 1, wr1_cnt, 1);
      check("single wr cycle", 1, wr1_cyc, 2);
      check("single wr addr", 1, wr1_addr, 16'hFFFF);
      check("single ee cycle", 1, ee_cyc[1], 4);

      // Wait high for 5 clocks during byte 1's strobe.
      run_load(22, 5, 5, -1);
      check("wait hold addr1", 0, hold1, 6);
      check("wait ee cycle", 2, ee_cyc[2], 18);
      check("wait no effect", 1, ee_cyc[1], 4);

      // Restart after byte 2 is written: edge sampled at cycle 10.
      run_load(28, -1, 0, 9);
      check("restart wr count", 0, wr_log.size(), 7);
      if (wr_log.size() > 3) begin
         check("restart first addr", 0, wr_log[3].addr, 16'h0000);
         check("restart first cycle", 0, wr_log[3].cyc, 12);
      end
      check("restart ee count", 2, ee_cnt[2], 1);
      check("restart ee cycle", 2, ee_cyc[2], 23);
      check("restart ee count", 1, ee_cnt[1], 2);

      // Reset during byte 1, then release with start held high.
      @(posedge clk_sys); #1 start = 1'b1;
      for (int n = 0; n <= 5; n++) begin @(posedge clk_sys); #1 start = 1'b0; end
      check("pre-reset strobe", 0, dn_wr[0], 1'b1);
      start = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("async dn_wr", 0, dn_wr[0], 1'b0);
      check("async dn_go", 0, dn_go[0], 1'b0);
      check("async dn_addr", 0, dn_addr[0], 16'h0000);
      check("async dn_data", 0, dn_data[0], 8'h00);
      check("async rom_addr", 0, rom_addr[0], 16'h0000);
      @(negedge clk_sys); reset_n = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      check("reboot strobe", 0, dn_wr[0], 1'b1);
      check("reboot addr", 0, dn_addr[0], 16'h0000);
      start = 1'b0;
      repeat (16) @(posedge clk_sys);

      // Randomized traffic: start toggles, image select, stalls, resets.
      repeat (3000) begin
         @(posedge clk_sys); #1;
         if ($urandom_range(0, 23) == 0) start = ~start;
         model   = 1'($urandom_range(0, 1));
         dn_wait = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset_n = 1'b0;
            #3 reset_n = 1'b1;
         end
      end
      start = 1'b0; dn_wait = 1'b0;
      repeat (20) @(posedge clk_sys);
      @(negedge clk_sys);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
